// File: rtl/rca_pipe_adder.sv
// Pipelined segmented ripple-carry add/subtract: capture register, then one SEG-bit ripple stage per register.
// Define RCA_PIPE_OVF_EN to add the signed-overflow output ovf.
module rca_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTG = WIDTH / SEG;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  // Index 0 is the operand capture register; index k (1..NSTG) holds the result of segment k-1.
  // Operands shift right by SEG per stage so the live segment always sits in the low bits;
  // finished sum segments enter at the top and shift down into place.
  logic             vld_q [0:NSTG];
  logic             vld_d [0:NSTG];
  logic [WIDTH-1:0] opa_q [0:NSTG];
  logic [WIDTH-1:0] opa_d [0:NSTG];
  logic [WIDTH-1:0] opb_q [0:NSTG];
  logic [WIDTH-1:0] opb_d [0:NSTG];
  logic [WIDTH-1:0] sum_q [0:NSTG];
  logic [WIDTH-1:0] sum_d [0:NSTG];
  logic             cry_q [0:NSTG];
  logic             cry_d [0:NSTG];
  logic [SEG:0]     seg_w [1:NSTG];
  logic             adv;

  assign adv       = !vld_q[NSTG] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NSTG];
  assign s         = sum_q[NSTG];
  assign cout      = cry_q[NSTG];

  always_comb begin
    // capture: subtraction folds into B inversion plus a forced carry-in
    vld_d[0] = in_valid;
    opa_d[0] = a;
    opb_d[0] = sub ? ~b : b;
    sum_d[0] = '0;
    cry_d[0] = sub | cin;
    for (int k = 1; k <= NSTG; k++) begin
      // segment stage k-1
      seg_w[k] = seg_add(opa_q[k-1][SEG-1:0], opb_q[k-1][SEG-1:0], cry_q[k-1]);
      vld_d[k] = vld_q[k-1];
      opa_d[k] = opa_q[k-1] >> SEG;
      opb_d[k] = opb_q[k-1] >> SEG;
      sum_d[k] = (sum_q[k-1] >> SEG) | (WIDTH'(seg_w[k][SEG-1:0]) << (WIDTH - SEG));
      cry_d[k] = seg_w[k][SEG];
    end
  end

`ifdef RCA_PIPE_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // carry into the MSB is recovered as a ^ b ^ sum at that bit
  always_comb begin
    ovf_d = opa_q[NSTG-1][SEG-1] ^ opb_q[NSTG-1][SEG-1] ^ seg_w[NSTG][SEG-1] ^ seg_w[NSTG][SEG];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= NSTG; k++) begin
        vld_q[k] <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
        cry_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k <= NSTG; k++) begin
        vld_q[k] <= vld_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
        cry_q[k] <= cry_d[k];
      end
    end
  end

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Bench for rca_pipe_adder: directed latency/stall/reset cases plus randomized traffic vs. a queue-based model.
module tb_rca_pipe_adder;

  localparam int WIDTH = 64;
  localparam int SEG   = 16;
  localparam int NSTG  = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             cin_i = 1'b0;
  logic             sub_i = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t q[$];

  rca_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
    .sub       (sub_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef RCA_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic sb);
    exp_t             e;
    logic [WIDTH-1:0] ye;
    logic [WIDTH:0]   full;
    ye   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, (sb | ci)};
    e.s  = full[WIDTH-1:0];
    e.c  = full[WIDTH];
    e.o  = (x[WIDTH-1] == ye[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return WIDTH'($urandom_range(0, 65535));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // scoreboard: record accepted operands, compare every delivered result in order
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("sb_s", s, e.s);
          chk("sb_cout", cout, e.c);
`ifdef RCA_PIPE_OVF_EN
          chk("sb_ovf", ovf, e.o);
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(model(a_i, b_i, cin_i, sub_i));
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic ci, input logic sb);
    int n;
    a_i = x; b_i = y; cin_i = ci; sub_i = sb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NSTG + 2) @(negedge clk);
    chk("drain_empty", q.size(), 0);
  endtask

  // single op into an empty pipe: out_valid must pulse exactly once, NSTG edges after acceptance
  task automatic lat_check(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic ci, input logic sb,
                           input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    a_i = x; b_i = y; cin_i = ci; sub_i = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("lat_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i <= NSTG + 1; i++) begin
      @(negedge clk);
      chk("lat_vld", out_valid, (i == NSTG));
      if (i == NSTG) begin
        chk("lat_s", s, es);
        chk("lat_cout", cout, ec);
`ifdef RCA_PIPE_OVF_EN
        chk("lat_ovf", ovf, eo);
`else
        if (eo === 1'bx) chk("lat_eo", eo, 0);
`endif
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
`ifdef RCA_PIPE_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);

    // all-ones + 1 wraps to zero with carry out
    lat_check(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);

    // back-to-back stream
    @(posedge clk); #1;
    send(64'h1, 64'h2, 1'b0, 1'b0);
    send(64'h3, 64'h4, 1'b1, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    send(64'hFFFF, 64'h1, 1'b0, 1'b0);
    drain();

    // subtraction, carry-in ignored; then signed-overflow corners
    lat_check(64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    lat_check(64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0);
    lat_check(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    lat_check(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // backpressure: fill, stall 3 cycles with a pending op, then release
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    out_ready = 1'b0;
    a_i = rnd(); b_i = rnd(); cin_i = 1'b1; sub_i = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rdy", in_ready, 0);
      chk("stall_vld", out_valid, 1);
      chk("stall_s", s, q[0].s);
      chk("stall_cout", cout, q[0].c);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // reset with results in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(64'h3, 64'h4, 1'b0, 1'b0);
    send(64'h10, 64'h20, 1'b0, 1'b0);
    send(64'hFFFF, 64'hFFFF, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_prefill", out_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", out_valid, 0);
    chk("rst_async_s", s, 0);
    chk("rst_async_cout", cout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (NSTG + 2) begin
      @(negedge clk);
      chk("rst_stale", out_valid, 0);
    end
    lat_check(64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0);

    // randomized traffic with random bubbles and backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a_i       = rnd();
      b_i       = rnd();
      cin_i     = 1'($urandom_range(0, 1));
      sub_i     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_pipe_adder.md
Name: rca_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's fixed 64-bit ripple-carry adder.
- Splits a WIDTH-bit add or subtract into WIDTH/SEG ripple segments, with one register stage per segment.
- Carry is registered between segments; operand skew and result deskew registers keep every transaction aligned.
- Valid/ready handshake on both sides; sits between operand-producing logic and any ready-capable consumer in the arithmetic datapath.

Parameters:
- WIDTH, 64, total operand/result width; must be a multiple of SEG.
- SEG, 16, bits per ripple segment = per pipeline stage.
- NSTG, WIDTH/SEG (derived localparam), number of pipeline stages = latency in cycles.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  operand transaction present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  1 = A-B (B inverted, carry-in forced 1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry-out of MSB segment; for sub it is the no-borrow flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits, data, carry and skew registers clear to 0;
  - out_valid=0, s=0, cout=0 (and ovf=0 when compiled in);
  - in_ready=1 once reset is released.
- Advance condition: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - Whole pipeline shifts only when adv=1; otherwise every register holds.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready.
  - The beff = sub ? ~b : b inversion and c0 = sub ? 1 : cin are applied at capture.
- Stage k (0..NSTG-1):
  - adds segment k of a and beff plus the carry from stage k-1 (c0 for stage 0);
  - registers the SEG-bit partial sum and the carry;
  - higher segments travel in skew registers, lower result segments in deskew registers.
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+NSTG, assuming no stall. Throughput is one per cycle.
- Bubbles: in_valid=0 with adv=1 inserts an invalid slot. Bubbles propagate and are not collapsed.
- Stall: out_valid=1 && out_ready=0:
  - s, cout, out_valid are held stable;
  - in_ready=0; no register changes.
- Simultaneous out_ready=1 and in_valid=1 while full: the result leaves and the new operand enters on the same edge.
- Width rules:
  - s = (a + beff + c0) mod 2^WIDTH;
  - cout = bit WIDTH of that sum;
  - no sign handling except under the optional feature.
- Reset mid-operation: all in-flight transactions are discarded and never emitted. out_valid drops asynchronously.
- WIDTH==SEG (NSTG=1): single-stage registered adder, latency 1.

Optional Feature:
- Macro: RCA_PIPE_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), aligned with s and cout;
  - ovf = signed overflow = carry into MSB XOR carry out of MSB, computed in the last stage;
  - reset value 0; held under stall like s.
- Undefined: port ovf is absent; no extra logic.

Test Plan (WIDTH=64, SEG=16, latency 4):
1. a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 -> after 4 cycles s=0, cout=1, out_valid=1 for exactly one cycle.
2. Stream 4 back-to-back ops: (1,2,0), (3,4,1), (0x8000_0000_0000_0000, 0x8000_0000_0000_0000, 0), (0xFFFF,1,0) -> cycles 4..7 give s=3, 8 (cout=0), 0 (cout=1), 0x10000.
3. Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles -> in_ready=0 and s/cout unchanged for those 3 cycles; release gives in-order delivery with no loss or duplication.
4. sub=1, a=5, b=7, cin=1 (ignored) -> s=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5 -> s=2, cout=1.
5. Reset asserted 2 cycles after accepting an op -> out_valid=0 immediately, s=0. After release there is no stale output, and a new op a=1, b=1 yields s=2 at latency 4.
6. With RCA_PIPE_OVF_EN: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> ovf=1, cout=0. Then a=0x8000_0000_0000_0000 with sub=1, b=1 -> ovf=1, s=0x7FFF_FFFF_FFFF_FFFF.
